vga_rom_arbiter: RTL

Shares one synchronous tile/sprite ROM between several drawing stages of the VGA pipeline (map platforms, ladders, barrels, score digits). Each stage issues a read request with an address. The arbiter grants one stage per cycle, drives the ROM address, and routes the returned pixel back, tagged to the requester that issued it. It sits beside the draw chain, between the draw stages and the single `rom_addr`/`rom_data` port of the shared image ROM.

---
 rtl/vga_rom_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/vga_rom_arbiter.sv
// vga_rom_arbiter: shares one synchronous tile/sprite ROM between several draw stages.
// One grant per cycle; the granted address is registered to the ROM. A one-hot tag rides
// a shift register alongside the read, so each returned pixel goes back to its requester.
// Build option: define VGA_ROM_ARB_RR_EN for round-robin priority.
// Without it, priority is fixed and the lowest requester index wins.
module vga_rom_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 12,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [15:0]               conflict_cnt
);

  logic [NUM_REQ-1:0] w_gnt;
  logic [ADDR_W-1:0]  w_win_addr;
  logic               w_found;
  logic               w_multi;

  logic [ADDR_W-1:0]  r_rom_addr;
  logic [NUM_REQ-1:0] r_tag [RD_LAT+1];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;
  logic [15:0]        r_conflict_cnt;

`ifdef VGA_ROM_ARB_RR_EN
  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;

  // Round-robin pick: first search indices at or above the pointer, then wrap to the rest.
  always_comb begin
    w_gnt      = '0;
    w_win_addr = '0;
    w_found    = 1'b0;
    w_ptr_nxt  = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[k] && (k >= int'(r_ptr))) begin
        w_found    = 1'b1;
        w_gnt[k]   = 1'b1;
        w_win_addr = req_addr[k*ADDR_W +: ADDR_W];
        w_ptr_nxt  = (k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[k]) begin
        w_found    = 1'b1;
        w_gnt[k]   = 1'b1;
        w_win_addr = req_addr[k*ADDR_W +: ADDR_W];
        w_ptr_nxt  = (k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1);
      end
    end
  end

  // Pointer moves past the winner; held in idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end
`else
  // Fixed priority pick: lowest set request index wins.
  always_comb begin
    w_gnt      = '0;
    w_win_addr = '0;
    w_found    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[k]) begin
        w_found    = 1'b1;
        w_gnt[k]   = 1'b1;
        w_win_addr = req_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end
`endif

  // More than one request bit set means somebody is denied this cycle.
  always_comb begin
    w_multi = |(req & (req - NUM_REQ'(1)));
  end

  // ROM address register; holds its value when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_addr <= '0;
    end else if (w_found) begin
      r_rom_addr <= w_win_addr;
    end
  end

  // Tag pipeline, one stage per cycle from address register to ROM data valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= RD_LAT; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      r_tag[0] <= w_gnt;
      for (int k = 1; k <= RD_LAT; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  // Response register: capture ROM data when a live tag leaves the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= r_tag[RD_LAT];
      if (|r_tag[RD_LAT]) begin
        r_rsp_data <= rom_data;
      end
    end
  end

  // Saturating conflict counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (w_multi && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign gnt          = w_gnt;
  assign rom_addr     = r_rom_addr;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign conflict_cnt = r_conflict_cnt;

endmodule
